// File: rtl/coletor_pin_pkg.sv
// coletor_pin_pkg: shared pinPac_t type, key codes and digit-shift helpers for the PIN collector
package coletor_pin_pkg;
  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;
  localparam logic [3:0] KEY_BACKSPACE = 4'hA;
  localparam logic [3:0] KEY_ENTER     = 4'hB;
  localparam logic [3:0] DIGIT_BLANK   = 4'hE;
  localparam pinPac_t    PIN_BLANK     = {1'b0, {4{DIGIT_BLANK}}};
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_SEND     = 3'd2,
    ST_COOLDOWN = 3'd3
  } state_t;
  // Newest digit enters at digit4, oldest falls out of digit1.
  function automatic pinPac_t pin_push(pinPac_t p, logic [3:0] d);
    return '{status: 1'b0, digit1: p.digit2, digit2: p.digit3, digit3: p.digit4, digit4: d};
  endfunction
  // Backspace drops digit4 and refills digit1 with the blank marker.
  function automatic pinPac_t pin_pop(pinPac_t p);
    return '{status: 1'b0, digit1: DIGIT_BLANK, digit2: p.digit1, digit3: p.digit2, digit4: p.digit3};
  endfunction
endpackage

// File: rtl/coletor_pin_if.sv
// coletor_pin_if: keypad inputs and pinPac_t outputs of the PIN collector
interface coletor_pin_if;
  import coletor_pin_pkg::*;
  logic       enable;
  logic       key_valid;
  logic [3:0] key_code;
  pinPac_t    pin_out;
  logic [2:0] digit_count;
  logic       entry_error;
  modport master (
    input  enable, key_valid, key_code,
    output pin_out, digit_count, entry_error
  );
  modport slave (
    output enable, key_valid, key_code,
    input  pin_out, digit_count, entry_error
  );
endinterface

// File: rtl/coletor_pin_contador_timeout.sv
// contador_timeout: down-counter that pulses o_expire N cycles after i_clear drops
module contador_timeout #(
  parameter int unsigned N = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_expire
);
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  logic [W-1:0] r_cnt;
  // Reload while cleared, then count down and park at zero.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= W'(N - 1);
    else if (i_clear) r_cnt <= W'(N - 1);
    else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
  assign o_expire = !i_clear && r_cnt == '0;
endmodule

// File: rtl/coletor_pin.sv
// coletor_pin: collects keypad digits into a 4-digit PIN and sends it on pinPac_t with a one-cycle status pulse
module coletor_pin
  import coletor_pin_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 50_000_000,
  parameter int unsigned COOLDOWN_CYCLES = 16
) (
  input logic           clk,
  input logic           rst,
  coletor_pin_if.master bus
);
  state_t     r_state, w_next;
  pinPac_t    r_pin, w_pin;
  logic [2:0] r_count, w_count;
  logic       r_error, w_error;
  logic       w_digit, w_bksp, w_enter, w_tmo, w_cd_done;
  assign w_digit = bus.key_valid && bus.key_code <= 4'd9;
  assign w_bksp  = bus.key_valid && bus.key_code == KEY_BACKSPACE;
  assign w_enter = bus.key_valid && bus.key_code == KEY_ENTER;
  // The accepting key cycle is cycle 0, so expiry lands in idle cycle TIMEOUT_CYCLES-1
  // and a key arriving in that same cycle wins because it holds the counter cleared.
  contador_timeout #(.N(TIMEOUT_CYCLES - 1)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state != ST_COLLECT || w_digit || w_bksp),
    .o_expire (w_tmo)
  );
  contador_timeout #(.N(COOLDOWN_CYCLES)) u_cooldown (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state != ST_COOLDOWN),
    .o_expire (w_cd_done)
  );
  // State register.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  // Next-state logic; SEND always completes regardless of enable.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:     w_next = bus.enable && w_digit ? ST_COLLECT : ST_IDLE;
      ST_COLLECT:  w_next = !bus.enable ? ST_IDLE :
                            w_digit     ? ST_COLLECT :
                            w_bksp      ? (r_count == 3'd1 ? ST_IDLE : ST_COLLECT) :
                            w_enter     ? (r_count == 3'd4 ? ST_SEND : ST_IDLE) :
                            w_tmo       ? ST_IDLE : ST_COLLECT;
      ST_SEND:     w_next = ST_COOLDOWN;
      ST_COOLDOWN: w_next = !bus.enable || w_cd_done ? ST_IDLE : ST_COOLDOWN;
      default:     w_next = ST_IDLE;
    endcase
  end
  // Next values of the registered outputs; status is high only when entering SEND.
  always_comb begin
    w_pin   = PIN_BLANK;
    w_count = 3'd0;
    w_error = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pin   = bus.enable && w_digit ? pin_push(PIN_BLANK, bus.key_code) : PIN_BLANK;
        w_count = bus.enable && w_digit ? 3'd1 : 3'd0;
      end
      ST_COLLECT: begin
        if (!bus.enable) begin
          w_pin   = PIN_BLANK;
        end else if (w_digit) begin
          w_pin   = pin_push(r_pin, bus.key_code);
          w_count = r_count == 3'd4 ? 3'd4 : r_count + 3'd1;
        end else if (w_bksp) begin
          w_pin   = pin_pop(r_pin);
          w_count = r_count - 3'd1;
        end else if (w_enter) begin
          w_pin        = r_count == 3'd4 ? r_pin : PIN_BLANK;
          w_pin.status = r_count == 3'd4;
          w_count      = r_count == 3'd4 ? r_count : 3'd0;
          w_error      = r_count != 3'd4;
        end else if (w_tmo) begin
          w_error = 1'b1;
        end else begin
          w_pin   = r_pin;
          w_count = r_count;
        end
      end
      default: begin
        w_pin = PIN_BLANK;
      end
    endcase
  end
  // Output registers.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pin   <= PIN_BLANK;
      r_count <= 3'd0;
      r_error <= 1'b0;
    end else begin
      r_pin   <= w_pin;
      r_count <= w_count;
      r_error <= w_error;
    end
  assign bus.pin_out     = r_pin;
  assign bus.digit_count = r_count;
  assign bus.entry_error = r_error;
endmodule

// File: tb/tb_coletor_pin.sv
// tb_coletor_pin: directed and random keypad traffic checked against a queue-based PIN entry model
module tb_coletor_pin;
  localparam int TO = 100;
  localparam int CD = 16;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0] q[$];
  bit   m_status, m_err, m_send;
  int   m_cool, m_idle;
  coletor_pin_if bus();
  coletor_pin #(.TIMEOUT_CYCLES(TO), .COOLDOWN_CYCLES(CD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_status = 0;
    m_err = 0;
    m_send = 0;
    m_cool = 0;
    m_idle = 0;
  endtask
  // One clock of PIN entry rules: the queue holds the typed digits, newest last.
  task automatic model(input bit en, input bit kv, input logic [3:0] c);
    m_status = 0;
    m_err = 0;
    if (m_send) begin
      m_send = 0;
      q.delete();
      m_cool = CD;
    end else if (m_cool > 0) begin
      m_cool = en ? m_cool - 1 : 0;
    end else if (!en) begin
      q.delete();
    end else if (kv && c <= 4'd9) begin
      q.push_back(c);
      if (q.size() > 4) void'(q.pop_front());
      m_idle = 0;
    end else if (kv && c == 4'hA && q.size() > 0) begin
      void'(q.pop_back());
      m_idle = 0;
    end else if (kv && c == 4'hB && q.size() > 0) begin
      if (q.size() == 4) begin
        m_send = 1;
        m_status = 1;
      end else begin
        q.delete();
        m_err = 1;
      end
    end else if (q.size() > 0) begin
      m_idle++;
      if (m_idle == TO - 1) begin
        q.delete();
        m_err = 1;
      end
    end
  endtask
  function automatic logic [16:0] exp_pin();
    logic [15:0] d = 16'hEEEE;
    for (int i = 0; i < q.size(); i++) d[(q.size() - 1 - i) * 4 +: 4] = q[i];
    return {m_status, d};
  endfunction
  task automatic cyc(input bit en, input bit kv, input logic [3:0] c);
    bus.enable = en;
    bus.key_valid = kv;
    bus.key_code = c;
    @(posedge clk);
    model(en, kv, c);
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk("model_pin", bus.pin_out, exp_pin());
    chk("model_count", bus.digit_count, q.size());
    chk("model_err", bus.entry_error, m_err);
  endtask
  task automatic press(input logic [3:0] c);
    cyc(1, 1, c);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1, 0, 4'h0);
  endtask
  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pin", bus.pin_out, 17'h0EEEE);
    chk("rst_cnt", bus.digit_count, 0);
    chk("rst_err", bus.entry_error, 0);
    rst = 1'b0;
    idle(3);
    press(1); press(2); press(3); press(4); press(4'hB);
    chk("send_1234", bus.pin_out, 17'h11234);
    idle(1);
    chk("post_send_pin", bus.pin_out, 17'h0EEEE);
    chk("post_send_cnt", bus.digit_count, 0);
    idle(20);
    press(9); press(1); press(2); press(3);
    chk("cnt_4th", bus.digit_count, 4);
    press(4);
    chk("cnt_sat", bus.digit_count, 4);
    press(5); press(4'hB);
    chk("send_2345", bus.pin_out, 17'h12345);
    idle(20);
    press(1); press(2); press(3); press(4'hA); press(7); press(8); press(4'hB);
    chk("send_1278", bus.pin_out, 17'h11278);
    idle(20);
    press(1); press(2); press(4'hB);
    chk("short_err", bus.entry_error, 1);
    chk("short_pin", bus.pin_out, 17'h0EEEE);
    idle(1);
    chk("short_err_pulse", bus.entry_error, 0);
    press(5); press(6); idle(TO - 2);
    chk("pre_tmo_err", bus.entry_error, 0);
    idle(1);
    chk("tmo_err", bus.entry_error, 1);
    chk("tmo_cnt", bus.digit_count, 0);
    idle(5);
    press(5); press(6); idle(TO - 2); press(7);
    chk("late_key_cnt", bus.digit_count, 3);
    chk("late_key_err", bus.entry_error, 0);
    idle(TO - 1);
    chk("tmo2_err", bus.entry_error, 1);
    press(5); idle(50); press(4'hC); idle(TO - 53);
    chk("ign_pre_err", bus.entry_error, 0);
    idle(1);
    chk("ign_tmo_err", bus.entry_error, 1);
    idle(5);
    press(1); press(2); press(3); press(4); press(4'hB);
    idle(1);
    press(8);
    chk("cool_ignore", bus.digit_count, 0);
    idle(CD - 2);
    press(9);
    chk("cool_last", bus.digit_count, 0);
    press(3);
    chk("fresh_cnt", bus.digit_count, 1);
    chk("fresh_pin", bus.pin_out, 17'h0EEE3);
    idle(5);
    press(1); press(2); press(3);
    cyc(0, 0, 4'h0);
    chk("en_drop_pin", bus.pin_out, 17'h0EEEE);
    chk("en_drop_cnt", bus.digit_count, 0);
    chk("en_drop_err", bus.entry_error, 0);
    cyc(0, 1, 4'h5);
    idle(3);
    press(1); press(2); press(3);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_pin", bus.pin_out, 17'h0EEEE);
    chk("rst_mid_cnt", bus.digit_count, 0);
    chk("rst_mid_err", bus.entry_error, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(3);
    press(6); press(7); press(8); press(9); press(4'hB);
    chk("send_6789", bus.pin_out, 17'h16789);
    cyc(0, 0, 4'h0);
    idle(20);
    for (int s = 0; s < 20; s++) begin
      int prob = (s % 3 == 0) ? 2 : 30;
      for (int i = 0; i < 200; i++) begin
        bit en = $urandom_range(0, 99) != 0;
        bit kv = $urandom_range(0, 99) < prob;
        logic [3:0] c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        cyc(en, kv, c);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/coletor_pin.md
Name: coletor_pin

Overview:
- Transmitter side of the pinPac_t interface.
- Collects keypad digits, handles backspace, enter and inactivity timeout, and presents a completed 4-digit PIN on pin_out with a single-cycle status pulse.
- Feeds the password-verification block, which edge-detects pin_out.status and latches the digits in that cycle.
- Sits between the debounced keypad scanner and the verifier in the door-lock top level.

Parameters:
- TIMEOUT_CYCLES, 50_000_000: idle clock cycles in COLLECT before the partial entry is discarded (1 s at 50 MHz).
- COOLDOWN_CYCLES, 16: cycles after a send during which keys are ignored; covers the verifier's return to its wait state.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  entry allowed; low clears the buffer and ignores keys
- key_valid  in  1  single-cycle pulse, key_code valid
- key_code  in  4  0x0-0x9 digit, 0xA backspace (*), 0xB enter (#), 0xC-0xF ignored
- pin_out  out  pinPac_t  {status, digit1..digit4}; digit1 = oldest digit
- digit_count  out  3  digits currently buffered, 0-4
- entry_error  out  1  one-cycle pulse: enter pressed with fewer than 4 digits, or timeout

Behaviour:
Reset and empty state:
- Reset (asynchronous, any state) sets state IDLE.
- Reset clears pin_out.status, digit_count and entry_error to 0.
- Reset sets all pin_out digits to 4'hE (blank marker). Blank is always 4'hE.
- All outputs are registered.

States:
- IDLE
  - enable && key_valid && digit: shift the digit in, count=1, go to COLLECT.
  - Backspace and enter are ignored.
- COLLECT
  - Digit: d1<=d2, d2<=d3, d3<=d4, d4<=new.
  - digit_count saturates at 4; with more than 4 digits, only the last 4 are kept.
  - Backspace: d4<=d3, d3<=d2, d2<=d1, d1<=E, count-1. Count reaching 0 returns to IDLE.
  - Enter with count==4: go to SEND.
  - Enter with count<4: entry_error=1 for one cycle, clear buffer, go to IDLE.
  - Timeout counter resets on every accepted key.
  - Counter reaching TIMEOUT_CYCLES-1 with no key: entry_error pulse, clear buffer, go to IDLE.
- SEND (exactly 1 cycle)
  - pin_out.status=1; digits hold the buffered PIN in this cycle.
  - Next cycle: status=0, digits set to E, count=0, go to COOLDOWN.
- COOLDOWN
  - Counts COOLDOWN_CYCLES, then goes to IDLE.
  - key_valid is ignored throughout.

Timing:
- Latency: a key pulse in cycle n is reflected in pin_out.digits and digit_count in cycle n+1.
- The enter pulse in cycle n gives status=1 in cycle n+1.
- pin_out.status is never high two consecutive cycles, so every send is a fresh rising edge.

Boundary conditions:
- enable low in any state except SEND: clear buffer, status=0, count=0, go to IDLE, no entry_error.
- enable low during SEND: the send completes, then the rule above applies.
- A key pulse in the same cycle as the timeout expiry is accepted; the timeout is cancelled.
- Ignored codes 0xC-0xF do not restart the timeout.
- Illegal state encodings go to IDLE.

Decomposition:
- Shared package holds:
  - pinPac_t, as already used by the verifier.
  - Key-code constants: KEY_BACKSPACE=4'hA, KEY_ENTER=4'hB.
  - Blank digit constant DIGIT_BLANK=4'hE.
- One natural sub-module: contador_timeout.
  - Parameterized down-counter with clear input and one-cycle expiry pulse.
  - Instantiated twice: inactivity timeout and cooldown.

Test Plan:
- Keys 1,2,3,4,#: pin_out = {status=1, 1,2,3,4} for exactly one cycle, one cycle after #. Next cycle the digits are all E and count=0.
- Keys 9,1,2,3,4,5,#: send {2,3,4,5}; digit_count reads 4 from the 4th key onward.
- Keys 1,2,3,*,7,8,#: send {1,2,7,8}. Keys 1,2,#: entry_error pulse, no status, buffer all E.
- Keys 5,6 then TIMEOUT_CYCLES idle (bench uses TIMEOUT_CYCLES=100): entry_error at cycle 100, count=0. A key at cycle 99 keeps the entry.
- Send 1,2,3,4,#, then press 8 during COOLDOWN (COOLDOWN_CYCLES=16): 8 is ignored. A key after cooldown starts a fresh entry with count=1.
- rst asserted mid-entry (3 digits) and enable dropped mid-entry: both give all-E digits, status=0, count=0, no entry_error.
